// File: rtl/calc_key_sequencer_if.sv
// Bundle of key-input, core-handshake and status signals for calc_key_sequencer.
// master: the sequencer side; slave: the key source / calculator core / display side.
interface calc_key_sequencer_if;
  logic        key_valid;
  logic [7:0]  key_code;
  logic [15:0] calc_a;
  logic [15:0] calc_b;
  logic [7:0]  calc_op;
  logic        calc_start;
  logic [31:0] calc_y;
  logic        calc_done;
  logic [15:0] cur_val;
  logic [31:0] result;
  logic        result_valid;
  logic [1:0]  err_code;

  modport master (
    input  key_valid, key_code, calc_y, calc_done,
    output calc_a, calc_b, calc_op, calc_start, cur_val, result, result_valid, err_code
  );

  modport slave (
    output key_valid, key_code, calc_y, calc_done,
    input  calc_a, calc_b, calc_op, calc_start, cur_val, result, result_valid, err_code
  );
endinterface

// File: rtl/calc_key_sequencer.sv
// Key-stream front end for the 16x16 calculator core: builds decimal operands,
// latches the operator, issues one start pulse, captures the result and allows
// chaining the result into the next operation.
//
// state  | meaning
// S_A    | entering operand A
// S_B    | entering operand B (operator latched)
// S_WAIT | start issued, waiting for calc_done or timeout
// S_RES  | result captured, next key starts new calc or chains
// S_ERR  | error latched, only 'C'/'c' leaves
module calc_key_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  calc_key_sequencer_if.master  bus
);

  typedef enum logic [2:0] {S_A, S_B, S_WAIT, S_RES, S_ERR} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d, cur_q, cur_d;
  logic [7:0]  op_q, op_d, tmo_q, tmo_d;
  logic [31:0] res_q, res_d;
  logic        start_q, start_d, rv_q, rv_d, bdig_q, bdig_d;
  logic [1:0]  err_q, err_d;

  logic        is_digit, is_op, is_eq, is_clr;
  logic [3:0]  digit;
  logic [15:0] acc_src;
  logic [19:0] acc_new;
  logic        acc_ovf;

  // Key classification; the low nibble of '0'..'9' is the digit value.
  always_comb begin
    is_digit = bus.key_valid && (bus.key_code >= 8'd48) && (bus.key_code <= 8'd57);
    is_op    = bus.key_valid && ((bus.key_code == 8'd43) || (bus.key_code == 8'd45) ||
                                 (bus.key_code == 8'd42) || (bus.key_code == 8'd47));
    is_eq    = bus.key_valid && (bus.key_code == 8'd61);
    is_clr   = bus.key_valid && ((bus.key_code == 8'd67) || (bus.key_code == 8'd99));
    digit    = bus.key_code[3:0];
    acc_src  = (state_q == S_B) ? b_q : a_q;
    acc_new  = 20'(acc_src) * 20'd10 + 20'(digit);
    acc_ovf  = |acc_new[19:16];
  end

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      start_q <= 1'b0;
      cur_q   <= '0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      err_q   <= '0;
      tmo_q   <= '0;
      bdig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      start_q <= start_d;
      cur_q   <= cur_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      bdig_q  <= bdig_d;
    end
  end

  // Next-state and datapath updates; 'C' overrides everything.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    start_d = 1'b0;
    cur_d   = cur_q;
    res_d   = res_q;
    rv_d    = rv_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    bdig_d  = bdig_q;
    if (is_clr) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      cur_d   = '0;
      rv_d    = 1'b0;
      err_d   = 2'd0;
    end else begin
      case (state_q)
        S_A: begin
          if (is_digit) begin
            if (acc_ovf) begin
              err_d   = 2'd1;
              state_d = S_ERR;
            end else begin
              a_d   = acc_new[15:0];
              cur_d = acc_new[15:0];
            end
          end else if (is_op) begin
            op_d    = bus.key_code;
            b_d     = '0;
            bdig_d  = 1'b0;
            cur_d   = '0;
            state_d = S_B;
          end
        end
        S_B: begin
          if (is_digit) begin
            if (acc_ovf) begin
              err_d   = 2'd1;
              state_d = S_ERR;
            end else begin
              b_d    = acc_new[15:0];
              cur_d  = acc_new[15:0];
              bdig_d = 1'b1;
            end
          end else if (is_op) begin
            if (!bdig_q) op_d = bus.key_code;
          end else if (is_eq) begin
            if ((op_q == 8'd47) && (b_q == 16'd0)) begin
              err_d   = 2'd2;
              state_d = S_ERR;
            end else begin
              start_d = 1'b1;
              tmo_d   = '0;
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.calc_done) begin
            res_d   = bus.calc_y;
            rv_d    = 1'b1;
            state_d = S_RES;
          end else if (tmo_q == TMO_LAST) begin
            err_d   = 2'd3;
            state_d = S_ERR;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end
        S_RES: begin
          if (is_digit) begin
            a_d     = 16'(digit);
            b_d     = '0;
            cur_d   = 16'(digit);
            rv_d    = 1'b0;
            state_d = S_A;
          end else if (is_op) begin
            if (res_q[31:16] == 16'd0) begin
              a_d     = res_q[15:0];
              op_d    = bus.key_code;
              b_d     = '0;
              bdig_d  = 1'b0;
              cur_d   = '0;
              rv_d    = 1'b0;
              state_d = S_B;
            end else begin
              err_d   = 2'd3;
              state_d = S_ERR;
            end
          end
        end
        S_ERR: ;
        default: state_d = S_A;
      endcase
    end
  end

  // Registered outputs.
  assign bus.calc_a       = a_q;
  assign bus.calc_b       = b_q;
  assign bus.calc_op      = op_q;
  assign bus.calc_start   = start_q;
  assign bus.cur_val      = cur_q;
  assign bus.result       = res_q;
  assign bus.result_valid = rv_q;
  assign bus.err_code     = err_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer: a table of per-cycle vectors with
// hand-computed expected outputs, plus hand-written timeout and chain-overflow runs.
module tb_calc_key_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  calc_key_sequencer_if bus ();

  calc_key_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        kv;
    logic [7:0]  k;
    logic        d;
    logic [31:0] y;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [7:0]  eop;
    logic        est;
    logic [15:0] ecur;
    logic [31:0] eres;
    logic        erv;
    logic [1:0]  eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, input logic kv, input logic [7:0] k,
                             input logic d, input logic [31:0] y,
                             input logic [15:0] ea, input logic [15:0] eb,
                             input logic [7:0] eop, input logic est,
                             input logic [15:0] ecur, input logic [31:0] eres,
                             input logic erv, input logic [1:0] eerr);
    vec_t t;
    t.r = r; t.kv = kv; t.k = k; t.d = d; t.y = y;
    t.ea = ea; t.eb = eb; t.eop = eop; t.est = est;
    t.ecur = ecur; t.eres = eres; t.erv = erv; t.eerr = eerr;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic kv, input logic [7:0] k,
                      input logic d, input logic [31:0] y);
    rst = r; bus.key_valid = kv; bus.key_code = k; bus.calc_done = d; bus.calc_y = y;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                            input logic [7:0] eop, input logic est, input logic [15:0] ecur,
                            input logic [31:0] eres, input logic erv, input logic [1:0] eerr);
    chk({tag, " calc_a"},       32'(bus.calc_a),       32'(ea));
    chk({tag, " calc_b"},       32'(bus.calc_b),       32'(eb));
    chk({tag, " calc_op"},      32'(bus.calc_op),      32'(eop));
    chk({tag, " calc_start"},   32'(bus.calc_start),   32'(est));
    chk({tag, " cur_val"},      32'(bus.cur_val),      32'(ecur));
    chk({tag, " result"},       bus.result,            eres);
    chk({tag, " result_valid"}, 32'(bus.result_valid), 32'(erv));
    chk({tag, " err_code"},     32'(bus.err_code),     32'(eerr));
  endtask

  initial begin
    rst = 1'b1; bus.key_valid = 1'b0; bus.key_code = '0; bus.calc_done = 1'b0; bus.calc_y = '0;
    #2;

    //              r  kv key  d  y           a      b   op  st cur    res  rv err
    vecs.push_back(v(1, 0, 0,   0, 0,          0,     0,  0,  0, 0,     0,   0, 0));
    // 12 + 34, done 3 cycles after start with a simultaneous (dropped) key
    vecs.push_back(v(0, 1, "1", 0, 0,          1,     0,  0,  0, 1,     0,   0, 0));
    vecs.push_back(v(0, 1, "2", 0, 0,          12,    0,  0,  0, 12,    0,   0, 0));
    vecs.push_back(v(0, 1, "+", 0, 0,          12,    0,  43, 0, 0,     0,   0, 0));
    vecs.push_back(v(0, 1, "3", 0, 0,          12,    3,  43, 0, 3,     0,   0, 0));
    vecs.push_back(v(0, 1, "4", 0, 0,          12,    34, 43, 0, 34,    0,   0, 0));
    vecs.push_back(v(0, 1, "=", 0, 0,          12,    34, 43, 1, 34,    0,   0, 0));
    vecs.push_back(v(0, 0, 0,   0, 0,          12,    34, 43, 0, 34,    0,   0, 0));
    vecs.push_back(v(0, 1, "5", 0, 0,          12,    34, 43, 0, 34,    0,   0, 0));
    vecs.push_back(v(0, 1, "3", 1, 46,         12,    34, 43, 0, 34,    46,  1, 0));
    // chain 46 - 6
    vecs.push_back(v(0, 1, "-", 0, 0,          46,    0,  45, 0, 0,     46,  0, 0));
    vecs.push_back(v(0, 1, "6", 0, 0,          46,    6,  45, 0, 6,     46,  0, 0));
    vecs.push_back(v(0, 1, "=", 0, 0,          46,    6,  45, 1, 6,     46,  0, 0));
    vecs.push_back(v(0, 0, 0,   1, 40,         46,    6,  45, 0, 6,     40,  1, 0));
    vecs.push_back(v(0, 1, "=", 0, 0,          46,    6,  45, 0, 6,     40,  1, 0));
    // new calc from result: 7 / 0 -> divide by zero
    vecs.push_back(v(0, 1, "7", 0, 0,          7,     0,  45, 0, 7,     40,  0, 0));
    vecs.push_back(v(0, 1, "/", 0, 0,          7,     0,  47, 0, 0,     40,  0, 0));
    vecs.push_back(v(0, 1, "0", 0, 0,          7,     0,  47, 0, 0,     40,  0, 0));
    vecs.push_back(v(0, 1, "=", 0, 0,          7,     0,  47, 0, 0,     40,  0, 2));
    vecs.push_back(v(0, 1, "+", 0, 0,          7,     0,  47, 0, 0,     40,  0, 2));
    vecs.push_back(v(0, 1, "C", 0, 0,          0,     0,  47, 0, 0,     40,  0, 0));
    // 7 / 5 -> start pulse with op 47
    vecs.push_back(v(0, 1, "7", 0, 0,          7,     0,  47, 0, 7,     40,  0, 0));
    vecs.push_back(v(0, 1, "/", 0, 0,          7,     0,  47, 0, 0,     40,  0, 0));
    vecs.push_back(v(0, 1, "5", 0, 0,          7,     5,  47, 0, 5,     40,  0, 0));
    vecs.push_back(v(0, 1, "=", 0, 0,          7,     5,  47, 1, 5,     40,  0, 0));
    vecs.push_back(v(0, 0, 0,   0, 0,          7,     5,  47, 0, 5,     40,  0, 0));
    vecs.push_back(v(0, 0, 0,   1, 1,          7,     5,  47, 0, 5,     1,   1, 0));
    vecs.push_back(v(0, 1, "c", 0, 0,          0,     0,  47, 0, 0,     1,   0, 0));
    // entry overflow at 65535*10+6
    vecs.push_back(v(0, 1, "6", 0, 0,          6,     0,  47, 0, 6,     1,   0, 0));
    vecs.push_back(v(0, 1, "5", 0, 0,          65,    0,  47, 0, 65,    1,   0, 0));
    vecs.push_back(v(0, 1, "5", 0, 0,          655,   0,  47, 0, 655,   1,   0, 0));
    vecs.push_back(v(0, 1, "3", 0, 0,          6553,  0,  47, 0, 6553,  1,   0, 0));
    vecs.push_back(v(0, 1, "5", 0, 0,          65535, 0,  47, 0, 65535, 1,   0, 0));
    vecs.push_back(v(0, 1, "6", 0, 0,          65535, 0,  47, 0, 65535, 1,   0, 1));
    vecs.push_back(v(0, 1, "+", 0, 0,          65535, 0,  47, 0, 65535, 1,   0, 1));
    vecs.push_back(v(0, 1, "C", 0, 0,          0,     0,  47, 0, 0,     1,   0, 0));
    // operator replacement only before the first B digit
    vecs.push_back(v(0, 1, "8", 0, 0,          8,     0,  47, 0, 8,     1,   0, 0));
    vecs.push_back(v(0, 1, "+", 0, 0,          8,     0,  43, 0, 0,     1,   0, 0));
    vecs.push_back(v(0, 1, "*", 0, 0,          8,     0,  42, 0, 0,     1,   0, 0));
    vecs.push_back(v(0, 1, "2", 0, 0,          8,     2,  42, 0, 2,     1,   0, 0));
    vecs.push_back(v(0, 1, "-", 0, 0,          8,     2,  42, 0, 2,     1,   0, 0));
    vecs.push_back(v(0, 1, "=", 0, 0,          8,     2,  42, 1, 2,     1,   0, 0));
    vecs.push_back(v(0, 0, 0,   0, 0,          8,     2,  42, 0, 2,     1,   0, 0));
    vecs.push_back(v(0, 0, 0,   0, 0,          8,     2,  42, 0, 2,     1,   0, 0));
    // reset mid-WAIT, late calc_done ignored, then fresh entry
    vecs.push_back(v(1, 0, 0,   0, 0,          0,     0,  0,  0, 0,     0,   0, 0));
    vecs.push_back(v(0, 0, 0,   1, 99,         0,     0,  0,  0, 0,     0,   0, 0));
    vecs.push_back(v(0, 1, "9", 0, 0,          9,     0,  0,  0, 9,     0,   0, 0));
    vecs.push_back(v(0, 1, "=", 0, 0,          9,     0,  0,  0, 9,     0,   0, 0));
    vecs.push_back(v(0, 1, "x", 0, 0,          9,     0,  0,  0, 9,     0,   0, 0));
    vecs.push_back(v(1, 1, "5", 0, 0,          0,     0,  0,  0, 0,     0,   0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].kv, vecs[i].k, vecs[i].d, vecs[i].y);
      expect_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].eop, vecs[i].est,
                 vecs[i].ecur, vecs[i].eres, vecs[i].erv, vecs[i].eerr);
    end

    // Timeout: err_code rises exactly 16 cycles after calc_start.
    step(1, 0, 0, 0, 0);
    step(0, 1, "5", 0, 0);
    step(0, 1, "*", 0, 0);
    step(0, 1, "3", 0, 0);
    step(0, 1, "=", 0, 0);
    expect_all("tmo start", 5, 3, 42, 1, 3, 0, 0, 0);
    for (int k = 1; k < 16; k++) begin
      step(0, 0, 0, 0, 0);
      chk($sformatf("tmo wait%0d err_code", k), 32'(bus.err_code), 32'd0);
      chk($sformatf("tmo wait%0d calc_start", k), 32'(bus.calc_start), 32'd0);
    end
    step(0, 0, 0, 0, 0);
    expect_all("tmo expire", 5, 3, 42, 0, 3, 0, 0, 3);
    step(0, 0, 0, 1, 32'd123);
    expect_all("tmo late done", 5, 3, 42, 0, 3, 0, 0, 3);

    // Chaining a result wider than 16 bits is an error.
    step(1, 0, 0, 0, 0);
    step(0, 1, "1", 0, 0);
    step(0, 1, "+", 0, 0);
    step(0, 1, "1", 0, 0);
    step(0, 1, "=", 0, 0);
    expect_all("big start", 1, 1, 43, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 32'h0001_0000);
    expect_all("big result", 1, 1, 43, 0, 1, 32'h0001_0000, 1, 0);
    step(0, 1, "+", 0, 0);
    expect_all("big chain", 1, 1, 43, 0, 1, 32'h0001_0000, 1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
